// File: rtl/ucdp_afifo_wrarb_if.sv
// Requester-side and FIFO-write-side signal bundle of the async FIFO write arbiter.
// The slave modport is the arbiter's view; the master modport is the driving environment.
interface ucdp_afifo_wrarb_if #(
  parameter int dwidth_p = 8,
  parameter int awidth_p = 4,
  parameter int nreq_p   = 4
);
  localparam int idwidth_p = (nreq_p > 1) ? $clog2(nreq_p) : 1;

  logic [nreq_p-1:0]            req_valid_i;
  logic [nreq_p*dwidth_p-1:0]   req_data_i;
  logic [nreq_p-1:0]            req_last_i;
  logic [nreq_p*awidth_p-1:0]   req_len_i;
  logic [nreq_p-1:0]            req_ready_o;
  logic                         src_wr_en_o;
  logic [idwidth_p+dwidth_p-1:0] src_wr_data_o;
  logic                         src_wr_full_i;
  logic [awidth_p-1:0]          src_wr_space_avail_i;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, req_len_i,
    input  src_wr_full_i, src_wr_space_avail_i,
    output req_ready_o, src_wr_en_o, src_wr_data_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, req_len_i,
    output src_wr_full_i, src_wr_space_avail_i,
    input  req_ready_o, src_wr_en_o, src_wr_data_o
  );
endinterface

// File: rtl/ucdp_afifo_wrarb.sv
// Round-robin burst arbiter feeding the write side of an async FIFO; writes are tagged {id, payload}.
// Optional macro UCDP_AFIFO_WRARB_SPACECHK_EN: grant only bursts that already fit in the FIFO.
module ucdp_afifo_wrarb #(
  parameter int dwidth_p = 8,
  parameter int awidth_p = 4,
  parameter int nreq_p   = 4
) (
  input  logic                src_clk_i,
  input  logic                src_rst_an_i,
  ucdp_afifo_wrarb_if.slave   bus_if,
  output logic [nreq_p-1:0]   grant_o,
  output logic                busy_o
);
  localparam int idwidth_p = (nreq_p > 1) ? $clog2(nreq_p) : 1;
  localparam logic [idwidth_p-1:0] last_id_lp = idwidth_p'(nreq_p - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q, state_d;
  logic [nreq_p-1:0]      grant_q, grant_d;
  logic [idwidth_p-1:0]   gid_q, gid_d;
  logic [idwidth_p-1:0]   prio_q, prio_d;

  logic [nreq_p-1:0]      elig;
  logic                   win_found;
  logic [idwidth_p-1:0]   win_id;
  logic [idwidth_p:0]     search_idx;
  logic                   cur_valid;
  logic                   cur_last;
  logic [dwidth_p-1:0]    cur_data;
  logic [nreq_p-1:0]      ready;
  logic                   wr_en;
  logic [idwidth_p+dwidth_p-1:0] wr_data;

  for (genvar i = 0; i < nreq_p; i++) begin : g_elig
`ifdef UCDP_AFIFO_WRARB_SPACECHK_EN
    assign elig[i] = bus_if.req_valid_i[i] &&
                     (bus_if.req_len_i[i*awidth_p +: awidth_p] != '0) &&
                     (bus_if.req_len_i[i*awidth_p +: awidth_p] <= bus_if.src_wr_space_avail_i);
`else
    assign elig[i] = bus_if.req_valid_i[i];
`endif
  end

`ifndef UCDP_AFIFO_WRARB_SPACECHK_EN
  logic unused_spacechk;
  assign unused_spacechk = ^{bus_if.req_len_i, bus_if.src_wr_space_avail_i};
`endif

  // First eligible requester at or after the priority pointer, wrapping around.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    search_idx = '0;
    for (int k = 0; k < nreq_p; k++) begin
      search_idx = {1'b0, prio_q} + (idwidth_p+1)'(k);
      if (search_idx >= (idwidth_p+1)'(nreq_p)) begin
        search_idx = search_idx - (idwidth_p+1)'(nreq_p);
      end
      if (!win_found && elig[search_idx[idwidth_p-1:0]]) begin
        win_found = 1'b1;
        win_id    = search_idx[idwidth_p-1:0];
      end
    end
  end

  always_comb begin
    cur_valid = bus_if.req_valid_i[gid_q];
    cur_last  = bus_if.req_last_i[gid_q];
    cur_data  = bus_if.req_data_i[int'(gid_q)*dwidth_p +: dwidth_p];
    ready     = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (state_q == BURST) begin
      ready = grant_q & {nreq_p{~bus_if.src_wr_full_i}};
      wr_en = cur_valid & ~bus_if.src_wr_full_i;
    end
    if (wr_en) begin
      wr_data = {gid_q, cur_data};
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          gid_d   = win_id;
          grant_d = {{(nreq_p-1){1'b0}}, 1'b1} << win_id;
        end
      end
      BURST: begin
        if (wr_en && cur_last) begin
          state_d = IDLE;
          grant_d = '0;
          gid_d   = '0;
          prio_d  = (gid_q == last_id_lp) ? '0 : gid_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
    if (!src_rst_an_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      prio_q  <= prio_d;
    end
  end

  assign bus_if.req_ready_o   = ready;
  assign bus_if.src_wr_en_o   = wr_en;
  assign bus_if.src_wr_data_o = wr_data;
  assign grant_o              = grant_q;
  assign busy_o               = (state_q == BURST);

`ifdef UCDP_AFIFO_WRARB_SPACECHK_EN
  // A granted burst was checked to fit, so the FIFO must never report full during it.
  a_no_full_stall : assert property (@(posedge src_clk_i) disable iff (!src_rst_an_i)
                                     !((state_q == BURST) && bus_if.src_wr_full_i));
`endif
endmodule

// File: tb/tb_ucdp_afifo_wrarb.sv
// Directed self-checking bench for ucdp_afifo_wrarb (4 requesters, 8-bit payload, 2-bit id).
// Observed vector layout: {grant[3:0], busy, ready[3:0], wr_en, wr_data[9:0]}.
module tb_ucdp_afifo_wrarb;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ucdp_afifo_wrarb_if #(.dwidth_p(DW), .awidth_p(AW), .nreq_p(NR)) bus_if ();

  logic [NR-1:0] grant;
  logic          busy;

  ucdp_afifo_wrarb #(.dwidth_p(DW), .awidth_p(AW), .nreq_p(NR)) dut (
    .src_clk_i    (clk),
    .src_rst_an_i (rst_n),
    .bus_if       (bus_if),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  logic [19:0] obs;
  assign obs = {grant, busy, bus_if.req_ready_o, bus_if.src_wr_en_o, bus_if.src_wr_data_o};

  function automatic logic [19:0] exp_wr(input logic [1:0] id, input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    return {oh, 1'b1, oh, 1'b1, id, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    bus_if.req_valid_i[i]       = v;
    bus_if.req_last_i[i]        = l;
    bus_if.req_data_i[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.req_valid_i          = '0;
    bus_if.req_last_i           = '0;
    bus_if.req_data_i           = '0;
    bus_if.req_len_i            = {NR{4'd1}};
    bus_if.src_wr_full_i        = 1'b0;
    bus_if.src_wr_space_avail_i = 4'd7;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req_valid_i          = 4'b1111;
    bus_if.req_last_i           = 4'b1111;
    bus_if.req_data_i           = 32'hDDCCBBAA;
    bus_if.req_len_i            = {NR{4'd1}};
    bus_if.src_wr_full_i        = 1'b0;
    bus_if.src_wr_space_avail_i = 4'd7;
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL reset_initial got %h exp %h", obs, 20'h0); end
    tick();
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL reset_held got %h exp %h", obs, 20'h0); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  id;
    logic [19:0] e;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      tick();
      e = exp_wr(id, 8'(8'hA0 + id));
      checks++;
      if (obs !== e) begin errors++; $display("[TB] FAIL rr_write%0d got %h exp %h", k, obs, e); end
      tick();
      if (k == 4) bus_if.req_valid_i = '0;
      #1;
      checks++;
      if (obs !== 20'h0) begin errors++; $display("[TB] FAIL rr_bubble%0d got %h exp %h", k, obs, 20'h0); end
    end
  endtask

  task automatic test_burst_no_interleave();
    do_reset();
    set_req(1, 1'b1, 1'b1, 8'h11);
    tick();
    checks++;
    if (obs !== exp_wr(2'd1, 8'h11)) begin errors++; $display("[TB] FAIL bi_pre got %h exp %h", obs, exp_wr(2'd1, 8'h11)); end
    tick();
    set_req(1, 1'b1, 1'b1, 8'h12);
    set_req(2, 1'b1, 1'b0, 8'h21);
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL bi_idle got %h exp %h", obs, 20'h0); end
    for (int b = 0; b < 3; b++) begin
      tick();
      set_req(2, 1'b1, (b == 2), 8'(8'h21 + b));
      #1;
      checks++;
      if (obs !== exp_wr(2'd2, 8'(8'h21 + b))) begin
        errors++; $display("[TB] FAIL bi_beat%0d got %h exp %h", b, obs, exp_wr(2'd2, 8'(8'h21 + b)));
      end
    end
    tick();
    set_req(2, 1'b0, 1'b0, 8'h00);
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL bi_after got %h exp %h", obs, 20'h0); end
    tick();
    checks++;
    if (obs !== exp_wr(2'd1, 8'h12)) begin errors++; $display("[TB] FAIL bi_req1 got %h exp %h", obs, exp_wr(2'd1, 8'h12)); end
    tick();
    bus_if.req_valid_i = '0;
  endtask

  task automatic test_full_stall();
    logic [19:0] e_stall;
    e_stall = {4'b0001, 1'b1, 4'b0000, 1'b0, 10'h0};
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h31);
    tick();
    checks++;
    if (obs !== exp_wr(2'd0, 8'h31)) begin errors++; $display("[TB] FAIL fs_beat1 got %h exp %h", obs, exp_wr(2'd0, 8'h31)); end
    tick();
    set_req(0, 1'b1, 1'b0, 8'h32);
    bus_if.src_wr_full_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (obs !== e_stall) begin errors++; $display("[TB] FAIL fs_stall%0d got %h exp %h", c, obs, e_stall); end
      tick();
    end
    bus_if.src_wr_full_i = 1'b0;
    #1;
    checks++;
    if (obs !== exp_wr(2'd0, 8'h32)) begin errors++; $display("[TB] FAIL fs_resume got %h exp %h", obs, exp_wr(2'd0, 8'h32)); end
    tick();
    set_req(0, 1'b1, 1'b1, 8'h33);
    #1;
    checks++;
    if (obs !== exp_wr(2'd0, 8'h33)) begin errors++; $display("[TB] FAIL fs_beat3 got %h exp %h", obs, exp_wr(2'd0, 8'h33)); end
    tick();
    bus_if.req_valid_i = '0;
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL fs_done got %h exp %h", obs, 20'h0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(2, 1'b1, 1'b1, 8'h51);
    tick();
    tick();
    set_req(2, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h61);
    tick();
    checks++;
    if (obs !== exp_wr(2'd0, 8'h61)) begin errors++; $display("[TB] FAIL ar_beat1 got %h exp %h", obs, exp_wr(2'd0, 8'h61)); end
    tick();
    set_req(0, 1'b1, 1'b0, 8'h62);
    #1;
    checks++;
    if (obs !== exp_wr(2'd0, 8'h62)) begin errors++; $display("[TB] FAIL ar_beat2 got %h exp %h", obs, exp_wr(2'd0, 8'h62)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL ar_immediate got %h exp %h", obs, 20'h0); end
    #2;
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h71);
    set_req(3, 1'b1, 1'b1, 8'h73);
    tick();
    checks++;
    if (obs !== exp_wr(2'd0, 8'h71)) begin errors++; $display("[TB] FAIL ar_prio0 got %h exp %h", obs, exp_wr(2'd0, 8'h71)); end
  endtask

  task automatic test_valid_drop();
    logic [19:0] e_hold;
    e_hold = {4'b0010, 1'b1, 4'b0010, 1'b0, 10'h0};
    do_reset();
    set_req(1, 1'b1, 1'b0, 8'h41);
    tick();
    checks++;
    if (obs !== exp_wr(2'd1, 8'h41)) begin errors++; $display("[TB] FAIL vd_beat1 got %h exp %h", obs, exp_wr(2'd1, 8'h41)); end
    tick();
    set_req(1, 1'b0, 1'b0, 8'h41);
    set_req(0, 1'b1, 1'b1, 8'h01);
    set_req(3, 1'b1, 1'b1, 8'h03);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (obs !== e_hold) begin errors++; $display("[TB] FAIL vd_hold%0d got %h exp %h", c, obs, e_hold); end
      tick();
    end
    set_req(1, 1'b1, 1'b1, 8'h42);
    #1;
    checks++;
    if (obs !== exp_wr(2'd1, 8'h42)) begin errors++; $display("[TB] FAIL vd_beat2 got %h exp %h", obs, exp_wr(2'd1, 8'h42)); end
    tick();
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== exp_wr(2'd3, 8'h03)) begin errors++; $display("[TB] FAIL vd_next_req3 got %h exp %h", obs, exp_wr(2'd3, 8'h03)); end
    tick();
    bus_if.req_valid_i = '0;
  endtask

`ifdef UCDP_AFIFO_WRARB_SPACECHK_EN
  task automatic test_space_check();
    do_reset();
    bus_if.src_wr_space_avail_i = 4'd2;
    bus_if.req_len_i[0 +: AW]  = 4'd4;
    bus_if.req_len_i[AW +: AW] = 4'd2;
    set_req(0, 1'b1, 1'b1, 8'h81);
    set_req(1, 1'b1, 1'b1, 8'h82);
    tick();
    checks++;
    if (obs !== exp_wr(2'd1, 8'h82)) begin errors++; $display("[TB] FAIL sc_req1 got %h exp %h", obs, exp_wr(2'd1, 8'h82)); end
    tick();
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== 20'h0) begin errors++; $display("[TB] FAIL sc_skip got %h exp %h", obs, 20'h0); end
    bus_if.src_wr_space_avail_i = 4'd4;
    tick();
    checks++;
    if (obs !== exp_wr(2'd0, 8'h81)) begin errors++; $display("[TB] FAIL sc_req0 got %h exp %h", obs, exp_wr(2'd0, 8'h81)); end
    tick();
    bus_if.req_valid_i = '0;
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_round_robin();
    test_burst_no_interleave();
`ifndef UCDP_AFIFO_WRARB_SPACECHK_EN
    test_full_stall();
`endif
    test_async_reset();
    test_valid_drop();
`ifdef UCDP_AFIFO_WRARB_SPACECHK_EN
    test_space_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
